// File: rtl/tia_timing_pkg.sv
// Shared TIA horizontal timing constants, CPU divider phases and the WSYNC halt-state encoding.
package tia_timing_pkg;

   localparam int unsigned LINE_CLOCKS_DEFAULT   = 228;
   localparam int unsigned HBLANK_CLOCKS_DEFAULT = 68;

   localparam logic [1:0] PHASE_0 = 2'd0;
   localparam logic [1:0] PHASE_1 = 2'd1;
   localparam logic [1:0] PHASE_2 = 2'd2;

   typedef enum logic {
      HALT_RUN  = 1'b0,
      HALT_WAIT = 1'b1
   } halt_state_e;

endpackage

// File: rtl/tia_phase_counter.sv
// Divide-by-three of the colour clock giving the CPU phase and its phi0 enable.
module tia_phase_counter
   import tia_timing_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       resync,
   output logic [1:0] phase,
   output logic       phi0_en,
   output logic       phi0_en_next
);

   logic [1:0] phase_q, phase_d;
   logic       phi0_en_q, phi0_en_d;

   // Resync restarts the sequence at phase 0, so phi0 returns two edges later.
   always_comb begin
      phase_d = PHASE_0;
      if (!resync) begin
         case (phase_q)
            PHASE_0: phase_d = PHASE_1;
            PHASE_1: phase_d = PHASE_2;
            default: phase_d = PHASE_0;
         endcase
      end
      phi0_en_d = (phase_d == PHASE_2);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_q   <= PHASE_0;
         phi0_en_q <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         phi0_en_q <= phi0_en_d;
      end
   end

   assign phase        = phase_q;
   assign phi0_en      = phi0_en_q;
   assign phi0_en_next = phi0_en_d;

endmodule

// File: rtl/tia_cpu_clock_sequencer.sv
// CPU phase, horizontal colour-clock position and WSYNC halt timing for the TIA.
module tia_cpu_clock_sequencer
   import tia_timing_pkg::*;
#(
   parameter int unsigned LINE_CLOCKS   = LINE_CLOCKS_DEFAULT,
   parameter int unsigned HBLANK_CLOCKS = HBLANK_CLOCKS_DEFAULT
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       resync,
   input  logic       wsync,
   output logic       phi0_en,
   output logic [1:0] phase,
   output logic       cpu_en,
   output logic       rdy,
   output logic [7:0] hcount,
   output logic       line_start,
   output logic       hblank
);

   localparam logic [7:0] LAST_COUNT   = 8'(LINE_CLOCKS - 1);
   localparam logic [7:0] HBLANK_LIMIT = 8'(HBLANK_CLOCKS);

   logic        phi0_en_next;
   logic [7:0]  hcount_q, hcount_d;
   logic        line_start_q, line_start_d;
   logic        hblank_q, hblank_d;
   logic        cpu_en_q, cpu_en_d;
   logic        wrap;
   logic        wsync_accept;
   halt_state_e state_q, state_d;

   tia_phase_counter u_phase (
      .clk          (clk),
      .reset_n      (reset_n),
      .resync       (resync),
      .phase        (phase),
      .phi0_en      (phi0_en),
      .phi0_en_next (phi0_en_next)
   );

   assign wrap = (hcount_q == LAST_COUNT);

   // Flags are computed from the next count so they line up with hcount itself.
   always_comb begin
      hcount_d     = wrap ? 8'd0 : hcount_q + 8'd1;
      line_start_d = (hcount_d == 8'd0);
      hblank_d     = (hcount_d < HBLANK_LIMIT);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hcount_q     <= 8'd0;
         line_start_q <= 1'b1;
         hblank_q     <= 1'b1;
      end else begin
         hcount_q     <= hcount_d;
         line_start_q <= line_start_d;
         hblank_q     <= hblank_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= HALT_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // A WSYNC landing on the wrap cycle would be released on the same edge, so it is dropped.
   assign wsync_accept = wsync & phi0_en & ~wrap;

   always_comb begin
      state_d = state_q;
      case (state_q)
         HALT_RUN:  if (wsync_accept) state_d = HALT_WAIT;
         HALT_WAIT: if (wrap)         state_d = HALT_RUN;
         default:                     state_d = HALT_RUN;
      endcase
   end

   always_comb begin
      rdy      = (state_q == HALT_RUN);
      cpu_en_d = phi0_en_next & (state_d == HALT_RUN);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cpu_en_q <= 1'b0;
      end else begin
         cpu_en_q <= cpu_en_d;
      end
   end

   assign cpu_en     = cpu_en_q;
   assign hcount     = hcount_q;
   assign line_start = line_start_q;
   assign hblank     = hblank_q;

endmodule

// File: tb/tb_tia_cpu_clock_sequencer.sv
// Scoreboard bench for tia_cpu_clock_sequencer: directed scenarios plus random resync/wsync traffic.
module tb_tia_cpu_clock_sequencer;

   localparam int LINE = 228;
   localparam int HB   = 68;

   typedef struct packed {
      logic [1:0] phase;
      logic       phi0_en;
      logic       cpu_en;
      logic       rdy;
      logic [7:0] hcount;
      logic       line_start;
      logic       hblank;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       resync = 1'b0;
   logic       wsync = 1'b0;
   logic       phi0_en;
   logic [1:0] phase;
   logic       cpu_en;
   logic       rdy;
   logic [7:0] hcount;
   logic       line_start;
   logic       hblank;

   int   n_checks = 0;
   int   n_fail = 0;
   exp_t exp_q[$];

   int   m_phase = 0;
   int   m_hc = 0;
   bit   m_halted = 1'b0;
   bit   prev_rn = 1'b0;

   tia_cpu_clock_sequencer #(
      .LINE_CLOCKS   (LINE),
      .HBLANK_CLOCKS (HB)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .resync     (resync),
      .wsync      (wsync),
      .phi0_en    (phi0_en),
      .phase      (phase),
      .cpu_en     (cpu_en),
      .rdy        (rdy),
      .hcount     (hcount),
      .line_start (line_start),
      .hblank     (hblank)
   );

   always #5 clk = ~clk;

   // Reference behaviour: colour-clock position, CPU phase and a halted flag.
   function automatic exp_t model_out();
      exp_t e;
      e.phase      = 2'(m_phase);
      e.phi0_en    = (m_phase == 2);
      e.rdy        = !m_halted;
      e.cpu_en     = (m_phase == 2) && !m_halted;
      e.hcount     = 8'(m_hc);
      e.line_start = (m_hc == 0);
      e.hblank     = (m_hc < HB);
      return e;
   endfunction

   task automatic model_reset();
      m_phase  = 0;
      m_hc     = 0;
      m_halted = 1'b0;
   endtask

   task automatic model_step(input bit rs, input bit ws);
      bit at_end;
      bit take;
      at_end = (m_hc == LINE - 1);
      take   = !m_halted && ws && (m_phase == 2) && !at_end;
      if (m_halted && at_end) m_halted = 1'b0;
      else if (take)          m_halted = 1'b1;
      m_hc    = (m_hc + 1) % LINE;
      m_phase = rs ? 0 : (m_phase + 1) % 3;
   endtask

   task automatic cmp(input string name, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_fail++;
         $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
      end
   endtask

   task automatic check_output(input exp_t e);
      cmp("phase",      int'(phase),      int'(e.phase));
      cmp("phi0_en",    int'(phi0_en),    int'(e.phi0_en));
      cmp("cpu_en",     int'(cpu_en),     int'(e.cpu_en));
      cmp("rdy",        int'(rdy),        int'(e.rdy));
      cmp("hcount",     int'(hcount),     int'(e.hcount));
      cmp("line_start", int'(line_start), int'(e.line_start));
      cmp("hblank",     int'(hblank),     int'(e.hblank));
   endtask

   // A falling reset queues one entry for the immediate asynchronous check and one for the next edge.
   task automatic apply_stimulus(input bit rs, input bit ws, input bit rn);
      @(negedge clk);
      if (!rn) begin
         model_reset();
         if (prev_rn) exp_q.push_back(model_out());
         exp_q.push_back(model_out());
         resync  = rs;
         wsync   = ws;
         reset_n = 1'b0;
      end else begin
         resync  = rs;
         wsync   = ws;
         reset_n = 1'b1;
         model_step(rs, ws);
         exp_q.push_back(model_out());
      end
      prev_rn = rn;
   endtask

   task automatic run_until(input int target);
      for (int i = 0; i < 2 * LINE && m_hc != target; i++) apply_stimulus(1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      forever begin
         exp_t e;
         @(posedge clk or negedge reset_n);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output(e);
         end
      end
   end

   initial begin
      apply_stimulus(1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b0, 1'b1);

      while (m_phase != 1) apply_stimulus(1'b0, 1'b0, 1'b1);
      apply_stimulus(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 1'b0, 1'b1);

      run_until(17);
      apply_stimulus(1'b1, 1'b0, 1'b1);
      apply_stimulus(1'b0, 1'b1, 1'b1);
      apply_stimulus(1'b0, 1'b1, 1'b1);
      apply_stimulus(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 215; i++) apply_stimulus(1'b0, 1'($urandom_range(0, 1)), 1'b1);
      for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b0, 1'b1);

      run_until(224);
      apply_stimulus(1'b1, 1'b0, 1'b1);
      apply_stimulus(1'b0, 1'b0, 1'b1);
      apply_stimulus(1'b0, 1'b0, 1'b1);
      apply_stimulus(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b0, 1'b1);

      run_until(50);
      apply_stimulus(1'b1, 1'b0, 1'b1);
      apply_stimulus(1'b0, 1'b0, 1'b1);
      apply_stimulus(1'b0, 1'b0, 1'b1);
      apply_stimulus(1'b0, 1'b1, 1'b1);
      run_until(100);
      apply_stimulus(1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b0, 1'b1);

      for (int i = 0; i < 2500; i++) begin
         bit rs, ws, rn;
         rs = ($urandom_range(0, 15) == 0);
         ws = ($urandom_range(0, 2) == 0);
         rn = ($urandom_range(0, 299) != 0);
         apply_stimulus(rs, ws, rn);
      end
      apply_stimulus(1'b0, 1'b0, 1'b1);

      @(posedge clk);
      #3;
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
